// File: rtl/wash_cycle_controller.sv
// Wash program sequencer: lock, fill, detergent, wash, drain, N rinse passes, spin, done.
// Per-state cycle timer drives timed phases and fill/drain timeouts; door-open faults preempt everything.
module wash_cycle_controller #(
  parameter int TW            = 8,
  parameter int DET_CYCLES    = 4,
  parameter int WASH_CYCLES   = 20,
  parameter int RINSE_CYCLES  = 10,
  parameter int SPIN_CYCLES   = 15,
  parameter int FILL_TIMEOUT  = 50,
  parameter int DRAIN_TIMEOUT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       door_closed,
  input  logic       quick,
  input  logic [1:0] rinses,
  input  logic       water_full,
  input  logic       water_empty,
  input  logic       clear_fault,
  output logic       door_lock,
  output logic       water_valve,
  output logic       detergent_valve,
  output logic       wash_motor,
  output logic       drain_pump,
  output logic       spin_motor,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_LOCK        = 4'd1,
    S_FILL        = 4'd2,
    S_DETERGENT   = 4'd3,
    S_WASH        = 4'd4,
    S_DRAIN       = 4'd5,
    S_RINSE_FILL  = 4'd6,
    S_RINSE       = 4'd7,
    S_RINSE_DRAIN = 4'd8,
    S_SPIN        = 4'd9,
    S_DONE        = 4'd10,
    S_FAULT       = 4'd11
  } state_t;

  localparam int WASH_Q  = ((WASH_CYCLES  >> 1) < 1) ? 1 : (WASH_CYCLES  >> 1);
  localparam int RINSE_Q = ((RINSE_CYCLES >> 1) < 1) ? 1 : (RINSE_CYCLES >> 1);
  localparam int SPIN_Q  = ((SPIN_CYCLES  >> 1) < 1) ? 1 : (SPIN_CYCLES  >> 1);

  // Timer holds cycles already spent in the state, so a phase ends when it reads duration-1.
  localparam logic [TW-1:0] DET_LAST     = TW'(DET_CYCLES - 1);
  localparam logic [TW-1:0] WASH_N_LAST  = TW'(WASH_CYCLES - 1);
  localparam logic [TW-1:0] WASH_Q_LAST  = TW'(WASH_Q - 1);
  localparam logic [TW-1:0] RINSE_N_LAST = TW'(RINSE_CYCLES - 1);
  localparam logic [TW-1:0] RINSE_Q_LAST = TW'(RINSE_Q - 1);
  localparam logic [TW-1:0] SPIN_N_LAST  = TW'(SPIN_CYCLES - 1);
  localparam logic [TW-1:0] SPIN_Q_LAST  = TW'(SPIN_Q - 1);
  localparam logic [TW-1:0] FILL_LAST    = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] DRAIN_LAST   = TW'(DRAIN_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      rinse_cnt_q, rinse_cnt_d;
  logic            quick_q, quick_d;
  logic [1:0]      err_q, err_d;
  logic [TW-1:0]   wash_last, rinse_last, spin_last;
  logic            in_prog;

  assign wash_last  = quick_q ? WASH_Q_LAST  : WASH_N_LAST;
  assign rinse_last = quick_q ? RINSE_Q_LAST : RINSE_N_LAST;
  assign spin_last  = quick_q ? SPIN_Q_LAST  : SPIN_N_LAST;
  assign in_prog    = (state_q >= S_LOCK) && (state_q <= S_SPIN);

  always_comb begin
    state_d     = state_q;
    rinse_cnt_d = rinse_cnt_q;
    quick_d     = quick_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_closed) begin
          state_d     = S_LOCK;
          quick_d     = quick;
          rinse_cnt_d = rinses;
        end
      end
      S_LOCK:      state_d = S_FILL;
      S_FILL, S_RINSE_FILL: begin
        if (water_full) begin
          state_d = (state_q == S_FILL) ? S_DETERGENT : S_RINSE;
        end else if (timer_q == FILL_LAST) begin
          state_d = S_FAULT;
          err_d   = 2'd2;
        end
      end
      S_DETERGENT: if (timer_q == DET_LAST) state_d = S_WASH;
      S_WASH:      if (timer_q == wash_last) state_d = S_DRAIN;
      S_RINSE:     if (timer_q == rinse_last) state_d = S_RINSE_DRAIN;
      S_SPIN:      if (timer_q == spin_last) state_d = S_DONE;
      S_DRAIN, S_RINSE_DRAIN: begin
        if (water_empty) begin
          if (rinse_cnt_q != 2'd0) begin
            state_d     = S_RINSE_FILL;
            rinse_cnt_d = rinse_cnt_q - 2'd1;
          end else begin
            state_d = S_SPIN;
          end
        end else if (timer_q == DRAIN_LAST) begin
          state_d = S_FAULT;
          err_d   = 2'd3;
        end
      end
      S_DONE:      state_d = S_IDLE;
      S_FAULT: begin
        if (clear_fault && water_empty) begin
          state_d = S_IDLE;
          err_d   = 2'd0;
        end
      end
      default:     state_d = S_IDLE;
    endcase

    // An open door overrides any sensor exit or timer expiry decided above.
    if (in_prog && !door_closed) begin
      state_d     = S_FAULT;
      err_d       = 2'd1;
      rinse_cnt_d = rinse_cnt_q;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == '1) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      rinse_cnt_q <= 2'd0;
      quick_q     <= 1'b0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rinse_cnt_q <= rinse_cnt_d;
      quick_q     <= quick_d;
      err_q       <= err_d;
    end
  end

  assign door_lock       = in_prog;
  assign busy            = in_prog;
  assign water_valve     = (state_q == S_FILL) || (state_q == S_RINSE_FILL);
  assign detergent_valve = (state_q == S_DETERGENT);
  assign wash_motor      = (state_q == S_WASH) || (state_q == S_RINSE);
  assign drain_pump      = (state_q == S_DRAIN) || (state_q == S_RINSE_DRAIN) || (state_q == S_FAULT);
  assign spin_motor      = (state_q == S_SPIN);
  assign done            = (state_q == S_DONE);
  assign error           = (state_q == S_FAULT);
  assign err_code        = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller: expected per-cycle state/err_code schedules are
// built from phase durations, and outputs are derived from the expected state by the output table.
module tb_wash_cycle_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       door_closed;
  logic       quick;
  logic [1:0] rinses;
  logic       water_full;
  logic       water_empty;
  logic       clear_fault;
  logic       door_lock, water_valve, detergent_valve, wash_motor;
  logic       drain_pump, spin_motor, busy, done, error;
  logic [1:0] err_code;
  logic [3:0] state_o;

  wash_cycle_controller dut (
    .clk(clk), .reset(reset), .start(start), .door_closed(door_closed),
    .quick(quick), .rinses(rinses), .water_full(water_full),
    .water_empty(water_empty), .clear_fault(clear_fault),
    .door_lock(door_lock), .water_valve(water_valve),
    .detergent_valve(detergent_valve), .wash_motor(wash_motor),
    .drain_pump(drain_pump), .spin_motor(spin_motor), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int gcyc = 0;
  int done_at = -1;
  int busy_tot = 0, wm_tot = 0, sp_tot = 0, wv_tot = 0;
  int t0, busy0, wm0, sp0, wv0;

  // Output table: which outputs are high in each program state.
  function automatic logic [8:0] decode(input int st);
    logic in_prog;
    in_prog = (st >= 1) && (st <= 9);
    return {in_prog, (st == 2 || st == 6), (st == 3), (st == 4 || st == 7),
            (st == 5 || st == 8 || st == 11), (st == 9), in_prog, (st == 10), (st == 11)};
  endfunction

  function automatic int dur(input int base, input int q);
    int h;
    h = base >> 1;
    if (q != 0) return (h < 1) ? 1 : h;
    return base;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, gcyc);
    end
  endtask

  task automatic push(input int st, input int n, input int ec);
    exp_t e;
    e.st = st;
    e.ec = ec;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One clock cycle: compare on the falling edge, then move to just after the next rising edge.
  task automatic step();
    exp_t e;
    logic [8:0] got;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {door_lock, water_valve, detergent_valve, wash_motor, drain_pump,
             spin_motor, busy, done, error};
      check("state_o", int'(state_o), e.st);
      check("outputs", int'(got), int'(decode(e.st)));
      check("err_code", int'(err_code), e.ec);
    end
    if (done) done_at = gcyc;
    busy_tot += int'(busy);
    wm_tot   += int'(wash_motor);
    sp_tot   += int'(spin_motor);
    wv_tot   += int'(water_valve);
    gcyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("queue_drain", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic snap();
    t0 = gcyc; busy0 = busy_tot; wm0 = wm_tot; sp0 = sp_tot; wv0 = wv_tot;
  endtask

  // Full program with both sensors answering immediately; inputs are scrambled after
  // the accepting edge so the DUT must rely on its latched copies.
  task automatic run_prog(input int q, input int r, input bit hold);
    logic [1:0] r2;
    r2 = r[1:0];
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 4, 0);
    push(4, dur(20, q), 0); push(5, 1, 0);
    for (int k = 0; k < r; k++) begin
      push(6, 1, 0); push(7, dur(10, q), 0); push(8, 1, 0);
    end
    push(9, dur(15, q), 0); push(10, 1, 0); push(0, 1, 0);
    if (hold) begin
      push(1, 1, 0); push(2, 1, 0);
    end
    snap();
    start = 1'b1; quick = q[0]; rinses = r2;
    step();
    if (!hold) start = 1'b0;
    quick = ~q[0]; rinses = ~r2;
    run_queue();
    start = 1'b0;
    $display("program quick=%0d rinses=%0d hold=%0d done_cycle=%0d busy=%0d wash=%0d spin=%0d",
             q, r, hold, done_at - t0, busy_tot - busy0, wm_tot - wm0, sp_tot - sp0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b1; door_closed = 1'b1; quick = 1'b0; rinses = 2'd0;
    water_full = 1'b1; water_empty = 1'b1; clear_fault = 1'b0;
    @(posedge clk);
    #1;
    push(0, 2, 0);
    step(); step();
    reset = 1'b0; start = 1'b0;
    step();

    // Normal, one rinse.
    run_prog(0, 1, 0);
    check("A_done_cycle", done_at - t0, 55);
    check("A_busy_cycles", busy_tot - busy0, 54);
    check("A_wash_cycles", wm_tot - wm0, 30);

    // Quick, one rinse.
    run_prog(1, 1, 0);
    check("B_done_cycle", done_at - t0, 32);
    check("B_wash_cycles", wm_tot - wm0, 15);
    check("B_spin_cycles", sp_tot - sp0, 7);

    // No rinses: drain straight to spin.
    run_prog(0, 0, 0);
    check("C_done_cycle", done_at - t0, 43);
    check("C_fill_cycles", wv_tot - wv0, 1);

    // Fill timeout, then clear attempts with and without an empty drum.
    water_full = 1'b0;
    push(0, 1, 0); push(1, 1, 0); push(2, 50, 0); push(11, 3, 2);
    snap();
    start = 1'b1; quick = 1'b0; rinses = 2'd0;
    step();
    start = 1'b0;
    run_queue();
    check("fill_timeout_cycles", wv_tot - wv0, 50);
    check("fill_err_code", int'(err_code), 2);
    water_full = 1'b1;
    water_empty = 1'b0; clear_fault = 1'b1;
    push(11, 2, 2);
    run_queue();
    water_empty = 1'b1;
    push(11, 1, 2); push(0, 1, 0);
    run_queue();
    clear_fault = 1'b0;
    $display("fill timeout scenario complete at cycle %0d", gcyc);

    // Drain timeout in quick mode.
    water_empty = 1'b0;
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 4, 0);
    push(4, 10, 0); push(5, 50, 0); push(11, 2, 3);
    start = 1'b1; quick = 1'b1; rinses = 2'd0;
    step();
    start = 1'b0;
    run_queue();
    check("drain_err_code", int'(err_code), 3);
    clear_fault = 1'b1;
    push(11, 1, 3);
    run_queue();
    water_empty = 1'b1;
    push(11, 1, 3); push(0, 1, 0);
    run_queue();
    clear_fault = 1'b0;
    $display("drain timeout scenario complete at cycle %0d", gcyc);

    // Door opened for one cycle during WASH.
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 4, 0);
    push(4, 5, 0); push(11, 2, 1);
    start = 1'b1; quick = 1'b0; rinses = 2'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    door_closed = 1'b0;
    step();
    door_closed = 1'b1;
    step(); step();
    check("door_wash_motor", int'(wash_motor), 0);
    clear_fault = 1'b1;
    push(11, 1, 1); push(0, 1, 0);
    run_queue();
    clear_fault = 1'b0;

    // start with the door open is ignored.
    door_closed = 1'b0; start = 1'b1;
    push(0, 3, 0);
    run_queue();
    start = 1'b0; door_closed = 1'b1;
    $display("door scenarios complete at cycle %0d", gcyc);

    // Reset in the middle of SPIN.
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 4, 0);
    push(4, 20, 0); push(5, 1, 0); push(9, 3, 0);
    start = 1'b1; quick = 1'b0; rinses = 2'd0;
    step();
    start = 1'b0;
    run_queue();
    reset = 1'b1;
    push(9, 1, 0); push(0, 1, 0);
    run_queue();
    reset = 1'b0;
    check("reset_state", int'(state_o), 0);

    // Fresh program with newly latched quick/rinses; start held through DONE.
    run_prog(1, 2, 1);
    check("D_done_cycle", done_at - t0, 39);
    check("D_wash_cycles", wm_tot - wm0, 20);
    reset = 1'b1;
    push(3, 1, 0); push(0, 1, 0);
    run_queue();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
